// File: rtl/i2s_mic_capture.sv
// Master-mode I2S capture for a single MEMS microphone (left slot only).
// Generates BCLK/LRCLK from clk, deserialises DOUT, keeps the top OUT_BITS of
// each left sample and publishes NSAMP samples at a time on frame/new_t.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   enable   capture enable (level); low returns to IDLE, dropping partial data
//   DOUT     microphone serial data, asynchronous to clk
//   BCLK     bit clock, clk/(2*CLK_DIV), registered
//   LRCLK    word select, registered; low = left slot
//   frame    NSAMP packed samples, t0 (oldest) in the low OUT_BITS
//   new_t    one-clk pulse, frame updated on the same edge
//   busy     high while not IDLE
module i2s_mic_capture #(
  parameter int unsigned CLK_DIV       = 8,
  parameter int unsigned SLOT_BITS     = 32,
  parameter int unsigned SAMPLE_BITS   = 24,
  parameter int unsigned OUT_BITS      = 10,
  parameter int unsigned NSAMP         = 16,
  parameter int unsigned WARMUP_FRAMES = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      DOUT,
  output logic                      BCLK,
  output logic                      LRCLK,
  output logic [NSAMP*OUT_BITS-1:0] frame,
  output logic                      new_t,
  output logic                      busy
);

  localparam int unsigned DIV_W  = $clog2(CLK_DIV);
  localparam int unsigned BIT_W  = $clog2(2 * SLOT_BITS);
  localparam int unsigned SAMP_W = (NSAMP > 1) ? $clog2(NSAMP) : 1;
  localparam int unsigned WARM_W = $clog2(WARMUP_FRAMES + 1);
  localparam int unsigned SH_W   = OUT_BITS - 1;
  localparam int unsigned FW     = NSAMP * OUT_BITS;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(2 * SLOT_BITS - 1);
  localparam logic [BIT_W-1:0]  SLOT_B    = BIT_W'(SLOT_BITS);
  localparam logic [BIT_W-1:0]  OUT_B     = BIT_W'(OUT_BITS);
  localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(NSAMP - 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic                bclk_q, bclk_d;
  logic                lrclk_q, lrclk_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WARM_W-1:0]   warm_cnt_q, warm_cnt_d;
  logic [SAMP_W-1:0]   samp_cnt_q, samp_cnt_d;
  logic [SH_W-1:0]     shift_q, shift_d;
  logic [OUT_BITS-1:0] buf_q [NSAMP];
  logic [OUT_BITS-1:0] buf_d [NSAMP];
  logic [FW-1:0]       frame_q, frame_d;
  logic                new_t_q, new_t_d;
  logic                busy_q, busy_d;
  logic                flush_q, flush_d;
  logic                din_meta_q, din_meta_d;
  logic                din_sync_q, din_sync_d;

  // End of a half period; a fall of BCLK doubles as the capture strobe.
  logic                tick;
  logic                fall;
  logic [BIT_W-1:0]    bit_nxt;
  logic [OUT_BITS-1:0] word;

  assign tick    = (div_cnt_q == DIV_LAST);
  assign fall    = tick & bclk_q;
  assign bit_nxt = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
  assign word    = {shift_q, din_sync_q};

  // State register and all flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      div_cnt_q  <= '0;
      bclk_q     <= 1'b0;
      lrclk_q    <= 1'b0;
      bit_cnt_q  <= '0;
      warm_cnt_q <= '0;
      samp_cnt_q <= '0;
      shift_q    <= '0;
      for (int k = 0; k < NSAMP; k++) buf_q[k] <= '0;
      frame_q    <= '0;
      new_t_q    <= 1'b0;
      busy_q     <= 1'b0;
      flush_q    <= 1'b0;
      din_meta_q <= 1'b0;
      din_sync_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bclk_q     <= bclk_d;
      lrclk_q    <= lrclk_d;
      bit_cnt_q  <= bit_cnt_d;
      warm_cnt_q <= warm_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      shift_q    <= shift_d;
      for (int k = 0; k < NSAMP; k++) buf_q[k] <= buf_d[k];
      frame_q    <= frame_d;
      new_t_q    <= new_t_d;
      busy_q     <= busy_d;
      flush_q    <= flush_d;
      din_meta_q <= din_meta_d;
      din_sync_q <= din_sync_d;
    end
  end

  // Next-state, clock generation, deserialiser and frame publish.
  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    bclk_d     = bclk_q;
    lrclk_d    = lrclk_q;
    bit_cnt_d  = bit_cnt_q;
    warm_cnt_d = warm_cnt_q;
    samp_cnt_d = samp_cnt_q;
    shift_d    = shift_q;
    for (int k = 0; k < NSAMP; k++) buf_d[k] = buf_q[k];
    frame_d    = frame_q;
    new_t_d    = 1'b0;
    flush_d    = 1'b0;
    din_meta_d = DOUT;
    din_sync_d = din_meta_q;

    if (!enable) begin
      // Drop everything except the last published frame.
      state_d    = ST_IDLE;
      div_cnt_d  = '0;
      bclk_d     = 1'b0;
      lrclk_d    = 1'b0;
      bit_cnt_d  = '0;
      warm_cnt_d = '0;
      samp_cnt_d = '0;
      shift_d    = '0;
      for (int k = 0; k < NSAMP; k++) buf_d[k] = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_WARMUP;
        end

        ST_WARMUP, ST_CAPTURE: begin
          div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
          if (tick) bclk_d = ~bclk_q;
          if (fall) begin
            bit_cnt_d = bit_nxt;
            lrclk_d   = (bit_nxt >= SLOT_B);
          end

          if (state_q == ST_WARMUP) begin
            // Count whole LR frames; capture begins at a slot boundary.
            if (fall && (bit_cnt_q == BIT_LAST)) begin
              if (warm_cnt_q == WARM_LAST) begin
                state_d    = ST_CAPTURE;
                warm_cnt_d = '0;
              end else begin
                warm_cnt_d = warm_cnt_q + 1'b1;
              end
            end
          end else begin
            // Left-slot bits 1..OUT_BITS-1 shift in; bit OUT_BITS completes the word.
            if (fall && (bit_cnt_q != '0) && (bit_cnt_q < OUT_B)) begin
              shift_d = SH_W'(word);
            end
            if (fall && (bit_cnt_q == OUT_B)) begin
              buf_d[samp_cnt_q] = word;
              if (samp_cnt_q == SAMP_LAST) begin
                samp_cnt_d = '0;
                flush_d    = 1'b1;
              end else begin
                samp_cnt_d = samp_cnt_q + 1'b1;
              end
            end
            // Buffer is complete one clk after the last write.
            if (flush_q) begin
              for (int k = 0; k < NSAMP; k++) begin
                frame_d[k*OUT_BITS +: OUT_BITS] = buf_q[k];
              end
              new_t_d = 1'b1;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign BCLK  = bclk_q;
  assign LRCLK = lrclk_q;
  assign frame = frame_q;
  assign new_t = new_t_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_i2s_mic_capture.sv
// Bench for i2s_mic_capture: an I2S microphone model driven from the DUT's
// BCLK/LRCLK, a queue of expected truncated samples, and timing monitors.
module tb_i2s_mic_capture;

  localparam int unsigned CLK_DIV     = 8;
  localparam int unsigned SLOT_BITS   = 32;
  localparam int unsigned SAMPLE_BITS = 24;
  localparam int unsigned OUT_BITS    = 10;
  localparam int unsigned NSAMP       = 16;
  localparam int unsigned WARM        = 2;
  localparam int unsigned FW          = NSAMP * OUT_BITS;

  localparam int BCLK_PER  = 2 * CLK_DIV;
  localparam int LRF       = 2 * SLOT_BITS * BCLK_PER;
  localparam int FRAME_PER = NSAMP * LRF;
  // Warmup frames, then NSAMP-1 full LR frames, then the last sample completes
  // at the BCLK fall ending slot bit OUT_BITS, and new_t follows one clk later.
  localparam int FIRST_LAT = WARM * LRF + (NSAMP - 1) * LRF + (OUT_BITS + 1) * BCLK_PER + 1;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic          dout = 1'b0;
  logic          bclk;
  logic          lrclk;
  logic [FW-1:0] frame;
  logic          new_t;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int en_cyc = 0;
  int session = 0;
  int nt_cnt = 0;
  bit first_pending = 1'b0;

  logic [OUT_BITS-1:0] exp_q [$];

  i2s_mic_capture #(
    .CLK_DIV      (CLK_DIV),
    .SLOT_BITS    (SLOT_BITS),
    .SAMPLE_BITS  (SAMPLE_BITS),
    .OUT_BITS     (OUT_BITS),
    .NSAMP        (NSAMP),
    .WARMUP_FRAMES(WARM)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (enable),
    .DOUT   (dout),
    .BCLK   (bclk),
    .LRCLK  (lrclk),
    .frame  (frame),
    .new_t  (new_t),
    .busy   (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Picks the sample for left slot s of the current enable session and
  // records its expected truncated value once capture has begun.
  task automatic new_left(input int s, output logic [SAMPLE_BITS-1:0] smp);
    int c;
    c   = s - int'(WARM);
    smp = SAMPLE_BITS'($urandom);
    if (c >= 0) begin
      if (session == 0 && c < int'(NSAMP)) begin
        smp = SAMPLE_BITS'(c) << 14;
      end else if (session == 0 && c < int'(2 * NSAMP)) begin
        case (c - int'(NSAMP))
          0:       smp = 24'hFFC000;
          1:       smp = 24'h800000;
          2:       smp = 24'h7FFFFF;
          3:       smp = 24'h000000;
          4:       smp = 24'hFFFFFF;
          5:       smp = 24'h003FFF;
          default: smp = SAMPLE_BITS'($urandom);
        endcase
      end
      exp_q.push_back(OUT_BITS'(smp >> (SAMPLE_BITS - OUT_BITS)));
    end
  endtask

  // Microphone: new bit after each BCLK fall, slot start on each LRCLK edge.
  int                   pos = 0;
  int                   slot = 0;
  logic                 mic_bclk_p = 1'b0;
  logic                 mic_lr_p = 1'b0;
  logic [SAMPLE_BITS-1:0] cur = '0;

  always @(negedge clk) begin
    if (busy !== 1'b1) begin
      pos      = 0;
      slot     = 0;
      mic_lr_p = 1'b0;
      exp_q.delete();
      new_left(0, cur);
      dout     = 1'($urandom);
    end else if (mic_bclk_p === 1'b1 && bclk === 1'b0) begin
      if (lrclk != mic_lr_p) begin
        pos = 0;
        if (!lrclk) begin
          slot++;
          new_left(slot, cur);
        end
      end else begin
        pos++;
      end
      mic_lr_p = lrclk;
      if (pos >= 1 && pos <= int'(SAMPLE_BITS))
        dout = mic_lr_p ? 1'b1 : cur[SAMPLE_BITS-pos];
      else
        dout = 1'($urandom);
    end
    mic_bclk_p = bclk;
  end

  // new_t monitor: latency/period, pulse width and frame contents.
  logic nt_p = 1'b0;
  int   nt_w = 0;
  int   last_nt = 0;

  always @(negedge clk) begin
    if (new_t === 1'b1) begin
      if (!nt_p) begin
        nt_cnt++;
        if (first_pending) begin
          check("first_latency", cyc - en_cyc, FIRST_LAT);
          first_pending = 1'b0;
        end else begin
          check("frame_period", cyc - last_nt, FRAME_PER);
        end
        last_nt = cyc;
        if (exp_q.size() < int'(NSAMP)) begin
          check("expected_samples_avail", exp_q.size(), NSAMP);
        end else begin
          for (int k = 0; k < int'(NSAMP); k++) begin
            check($sformatf("s%0d_t%0d", session, k), frame[k*OUT_BITS +: OUT_BITS], exp_q.pop_front());
          end
        end
      end
      nt_w++;
    end else begin
      if (nt_p) check("new_t_width", nt_w, 1);
      nt_w = 0;
    end
    nt_p = (new_t === 1'b1);
  end

  // Clock monitor: BCLK period, LRCLK spacing and alignment to BCLK falls.
  logic tm_bclk_p = 1'b0;
  logic tm_lr_p = 1'b0;
  int   last_rise = -1;
  int   last_lr = -1;

  always @(negedge clk) begin
    if (busy === 1'b1) begin
      if (!tm_bclk_p && bclk === 1'b1) begin
        if (last_rise >= 0) check("bclk_period", cyc - last_rise, BCLK_PER);
        last_rise = cyc;
      end
      if (lrclk !== tm_lr_p) begin
        check("lr_on_bclk_fall", {tm_bclk_p, bclk}, 2'b10);
        if (last_lr < 0) check("lr_first", cyc - en_cyc, SLOT_BITS * BCLK_PER);
        else             check("lr_interval", cyc - last_lr, SLOT_BITS * BCLK_PER);
        last_lr = cyc;
      end
    end else begin
      last_rise = -1;
      last_lr   = -1;
    end
    tm_bclk_p = (bclk === 1'b1);
    tm_lr_p   = (lrclk === 1'b1);
  end

  task automatic wait_nt(input int target, input int budget);
    int n;
    n = 0;
    while (nt_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("new_t_count", nt_cnt, target);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bclk"},  bclk,  0);
    check({tag, "_lrclk"}, lrclk, 0);
    check({tag, "_new_t"}, new_t, 0);
    check({tag, "_busy"},  busy,  0);
    check({tag, "_frame"}, frame, 0);
  endtask

  initial begin
    logic [FW-1:0] saved;
    logic          bprev;
    int            toggles;

    reset_n = 1'b0;
    enable  = 1'b0;
    #23;
    check_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Disabled: no BCLK activity at all.
    toggles = 0;
    bprev   = bclk;
    repeat (1000) begin
      @(negedge clk);
      if (bclk !== bprev) toggles++;
      bprev = bclk;
    end
    check("idle_bclk_toggles", toggles, 0);
    check("idle_busy", busy, 0);

    // Session 0: ramp frame, extreme-value frame, random frame back to back.
    @(negedge clk);
    enable        = 1'b1;
    first_pending = 1'b1;
    @(negedge clk);
    en_cyc = cyc;
    check("busy_after_enable", busy, 1);
    wait_nt(3, FIRST_LAT + 2 * FRAME_PER + 100);

    // Drop enable once seven samples of the next frame are in.
    repeat (7300) @(negedge clk);
    saved  = frame;
    enable = 1'b0;
    @(negedge clk);
    check("dis_bclk",  bclk,  0);
    check("dis_lrclk", lrclk, 0);
    check("dis_busy",  busy,  0);
    check("dis_frame", frame, saved);
    repeat (50) @(negedge clk);
    check("dis_frame_held", frame, saved);
    check("dis_no_new_t", nt_cnt, 3);

    // Session 1: full warmup then sixteen fresh random samples.
    session       = 1;
    enable        = 1'b1;
    first_pending = 1'b1;
    @(negedge clk);
    en_cyc = cyc;
    wait_nt(4, FIRST_LAT + 100);

    // Asynchronous reset in the middle of a frame.
    repeat (3000) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    enable  = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
